// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded fields from ID, applies
// freeze/flush, forwards operands and keeps saturating debug counters.
module id_exe_reg #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             clr_cnt,
    input  logic             in_valid,
    input  logic [W-1:0]     in_pc,
    input  logic [W-1:0]     in_val_rn,
    input  logic [W-1:0]     in_val_rm,
    input  logic             in_imm,
    input  logic [11:0]      in_shift_operand,
    input  logic [3:0]       in_dest,
    input  logic [3:0]       in_src1,
    input  logic [3:0]       in_src2,
    input  logic [3:0]       in_exe_cmd,
    input  logic             in_mem_r_en,
    input  logic             in_mem_w_en,
    input  logic             in_wb_en,
    input  logic             in_b,
    input  logic             in_s,
    input  logic [3:0]       in_status,
    input  logic [1:0]       fwd_sel_rn,
    input  logic [1:0]       fwd_sel_rm,
    input  logic [W-1:0]     mem_fwd_val,
    input  logic [W-1:0]     wb_fwd_val,
    output logic             valid,
    output logic [W-1:0]     pc,
    output logic             imm,
    output logic [11:0]      shift_operand,
    output logic [3:0]       dest,
    output logic [3:0]       src1,
    output logic [3:0]       src2,
    output logic [3:0]       exe_cmd,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             b,
    output logic             s,
    output logic [3:0]       status,
    output logic [W-1:0]     val_rn,
    output logic [W-1:0]     val_rm,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_valid;
    logic [W-1:0]     r_pc;
    logic [W-1:0]     r_val_rn;
    logic [W-1:0]     r_val_rm;
    logic             r_imm;
    logic [11:0]      r_shift_operand;
    logic [3:0]       r_dest;
    logic [3:0]       r_src1;
    logic [3:0]       r_src2;
    logic [3:0]       r_exe_cmd;
    logic             r_mem_r_en;
    logic             r_mem_w_en;
    logic             r_wb_en;
    logic             r_b;
    logic             r_s;
    logic [3:0]       r_status;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic             w_load;
    logic             w_stall;
    logic             w_bubble;

    // Action decode: flush beats freeze, freeze beats load
    assign w_load   = !flush && !freeze;
    assign w_stall  = freeze && !flush;
    assign w_bubble = flush || (w_load && !in_valid);

    // Stage register: bubble on flush, hold on freeze, else capture;
    // control bits are masked so they never assert without valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid         <= 1'b0;
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_dest          <= '0;
            r_src1          <= '0;
            r_src2          <= '0;
            r_exe_cmd       <= '0;
            r_mem_r_en      <= 1'b0;
            r_mem_w_en      <= 1'b0;
            r_wb_en         <= 1'b0;
            r_b             <= 1'b0;
            r_s             <= 1'b0;
            r_status        <= '0;
        end else if (flush) begin
            r_valid         <= 1'b0;
            r_pc            <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_dest          <= '0;
            r_src1          <= '0;
            r_src2          <= '0;
            r_exe_cmd       <= '0;
            r_mem_r_en      <= 1'b0;
            r_mem_w_en      <= 1'b0;
            r_wb_en         <= 1'b0;
            r_b             <= 1'b0;
            r_s             <= 1'b0;
            r_status        <= '0;
        end else if (!freeze) begin
            r_valid         <= in_valid;
            r_pc            <= in_pc;
            r_val_rn        <= in_val_rn;
            r_val_rm        <= in_val_rm;
            r_imm           <= in_imm;
            r_shift_operand <= in_shift_operand;
            r_dest          <= in_dest;
            r_src1          <= in_src1;
            r_src2          <= in_src2;
            r_exe_cmd       <= in_exe_cmd;
            r_mem_r_en      <= in_mem_r_en && in_valid;
            r_mem_w_en      <= in_mem_w_en && in_valid;
            r_wb_en         <= in_wb_en && in_valid;
            r_b             <= in_b && in_valid;
            r_s             <= in_s && in_valid;
            r_status        <= in_status;
        end
    end

    // Saturating debug counters; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    // Same-cycle operand forwarding after the register
    always_comb begin
        val_rn = r_val_rn;
        val_rm = r_val_rm;
        case (fwd_sel_rn)
            2'b01:   val_rn = mem_fwd_val;
            2'b10:   val_rn = wb_fwd_val;
            default: val_rn = r_val_rn;
        endcase
        case (fwd_sel_rm)
            2'b01:   val_rm = mem_fwd_val;
            2'b10:   val_rm = wb_fwd_val;
            default: val_rm = r_val_rm;
        endcase
    end

    assign valid         = r_valid;
    assign pc            = r_pc;
    assign imm           = r_imm;
    assign shift_operand = r_shift_operand;
    assign dest          = r_dest;
    assign src1          = r_src1;
    assign src2          = r_src2;
    assign exe_cmd       = r_exe_cmd;
    assign mem_r_en      = r_mem_r_en;
    assign mem_w_en      = r_mem_w_en;
    assign wb_en         = r_wb_en;
    assign b             = r_b;
    assign s             = r_s;
    assign status        = r_status;
    assign stall_cnt     = r_stall_cnt;
    assign bubble_cnt    = r_bubble_cnt;

endmodule

// File: tb/tb_id_exe_reg.sv
// Bench for id_exe_reg: a transaction-level model predicts every output
// snapshot, which is queued at drive time and popped after the edge.
module tb_id_exe_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        imm;
        logic [11:0] sh;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  cmd;
        logic        mr;
        logic        mw;
        logic        wb;
        logic        b;
        logic        s;
        logic [3:0]  status;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [3:0]  stall;
        logic [3:0]  bubble;
    } snap_t;

    logic clk = 1'b0;
    logic rst, freeze, flush, clr_cnt, in_valid;
    logic [31:0] in_pc, in_val_rn, in_val_rm, mem_fwd_val, wb_fwd_val;
    logic in_imm, in_mem_r_en, in_mem_w_en, in_wb_en, in_b, in_s;
    logic [11:0] in_shift_operand;
    logic [3:0] in_dest, in_src1, in_src2, in_exe_cmd, in_status;
    logic [1:0] fwd_sel_rn, fwd_sel_rm;
    logic valid, imm, mem_r_en, mem_w_en, wb_en, b, s;
    logic [31:0] pc, val_rn, val_rm;
    logic [11:0] shift_operand;
    logic [3:0] dest, src1, src2, exe_cmd, status, stall_cnt, bubble_cnt;

    int checks = 0;
    int errors = 0;
    snap_t sb_q[$];
    snap_t m;        // model of registered state (rn/rm hold registered operands)
    snap_t exp_s, obs_s;

    id_exe_reg #(.W(32), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .clr_cnt(clr_cnt),
        .in_valid(in_valid), .in_pc(in_pc), .in_val_rn(in_val_rn), .in_val_rm(in_val_rm),
        .in_imm(in_imm), .in_shift_operand(in_shift_operand), .in_dest(in_dest),
        .in_src1(in_src1), .in_src2(in_src2), .in_exe_cmd(in_exe_cmd),
        .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en), .in_wb_en(in_wb_en),
        .in_b(in_b), .in_s(in_s), .in_status(in_status),
        .fwd_sel_rn(fwd_sel_rn), .fwd_sel_rm(fwd_sel_rm),
        .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
        .valid(valid), .pc(pc), .imm(imm), .shift_operand(shift_operand),
        .dest(dest), .src1(src1), .src2(src2), .exe_cmd(exe_cmd),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en), .b(b), .s(s),
        .status(status), .val_rn(val_rn), .val_rm(val_rm),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r);
        case (sel)
            2'b01:   return mem_fwd_val;
            2'b10:   return wb_fwd_val;
            default: return r;
        endcase
    endfunction

    function automatic snap_t exp_snap();
        snap_t e;
        e = m;
        e.rn = fwd(fwd_sel_rn, m.rn);
        e.rm = fwd(fwd_sel_rm, m.rm);
        return e;
    endfunction

    function automatic snap_t obs_snap();
        snap_t o;
        o.valid = valid; o.pc = pc; o.imm = imm; o.sh = shift_operand;
        o.dest = dest; o.src1 = src1; o.src2 = src2; o.cmd = exe_cmd;
        o.mr = mem_r_en; o.mw = mem_w_en; o.wb = wb_en; o.b = b; o.s = s;
        o.status = status; o.rn = val_rn; o.rm = val_rm;
        o.stall = stall_cnt; o.bubble = bubble_cnt;
        return o;
    endfunction

    // Model of one clock edge from the current inputs
    task automatic model_edge();
        snap_t n;
        n = m;
        if (!rst) begin
            n = '0;
        end else begin
            if (clr_cnt) begin
                n.stall = 4'h0;
                n.bubble = 4'h0;
            end else begin
                if (freeze && !flush && m.stall != 4'hF) n.stall = m.stall + 4'h1;
                if ((flush || (!freeze && !in_valid)) && m.bubble != 4'hF)
                    n.bubble = m.bubble + 4'h1;
            end
            if (flush) begin
                n = '0;
                n.stall = (clr_cnt) ? 4'h0 : m.stall;
                n.bubble = (clr_cnt || m.bubble == 4'hF) ? (clr_cnt ? 4'h0 : 4'hF) : m.bubble + 4'h1;
            end else if (!freeze) begin
                n.valid = in_valid; n.pc = in_pc; n.imm = in_imm; n.sh = in_shift_operand;
                n.dest = in_dest; n.src1 = in_src1; n.src2 = in_src2; n.cmd = in_exe_cmd;
                n.mr = in_mem_r_en & in_valid; n.mw = in_mem_w_en & in_valid;
                n.wb = in_wb_en & in_valid; n.b = in_b & in_valid; n.s = in_s & in_valid;
                n.status = in_status; n.rn = in_val_rn; n.rm = in_val_rm;
            end
        end
        m = n;
    endtask

    // Predict, queue the expectation, then advance one clock
    task automatic tick();
        model_edge();
        sb_q.push_back(exp_snap());
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ins();
        freeze = 0; flush = 0; clr_cnt = 0; in_valid = 1;
        in_pc = 32'h0; in_val_rn = 32'h0; in_val_rm = 32'h0; in_imm = 0;
        in_shift_operand = 12'h0; in_dest = 4'h0; in_src1 = 4'h0; in_src2 = 4'h0;
        in_exe_cmd = 4'h0; in_mem_r_en = 0; in_mem_w_en = 0; in_wb_en = 0;
        in_b = 0; in_s = 0; in_status = 4'h0;
        fwd_sel_rn = 2'b00; fwd_sel_rm = 2'b00; mem_fwd_val = 32'h0; wb_fwd_val = 32'h0;
    endtask

    task automatic rand_ins();
        in_valid = 1'($urandom); in_pc = $urandom; in_val_rn = $urandom; in_val_rm = $urandom;
        in_imm = 1'($urandom); in_shift_operand = 12'($urandom); in_dest = 4'($urandom);
        in_src1 = 4'($urandom); in_src2 = 4'($urandom); in_exe_cmd = 4'($urandom);
        in_mem_r_en = 1'($urandom); in_mem_w_en = 1'($urandom); in_wb_en = 1'($urandom);
        in_b = 1'($urandom); in_s = 1'($urandom); in_status = 4'($urandom);
        mem_fwd_val = $urandom; wb_fwd_val = $urandom;
        fwd_sel_rn = 2'($urandom); fwd_sel_rm = 2'($urandom);
    endtask

    task automatic test_reset();
        idle_ins();
        rst = 0;
        rand_ins();
        fwd_sel_rn = 2'b00; fwd_sel_rm = 2'b11;
        m = '0;
        #1;
        exp_s = exp_snap(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL reset_hold: got %h expected %h", obs_s, exp_s); end
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL reset_edge: got %h expected %h", obs_s, exp_s); end
        checks++;
        if (valid !== 1'b0 || val_rm !== 32'h0) begin
            errors++; $display("FAIL reset_zero: valid=%b val_rm=%h required 0", valid, val_rm);
        end
        rst = 1;
        idle_ins();
    endtask

    task automatic test_load();
        in_val_rm = 32'h0000_00F0; in_imm = 0; in_shift_operand = 12'h0E1; in_valid = 1;
        in_pc = 32'h0000_0104; in_dest = 4'h3; in_src1 = 4'h1; in_src2 = 4'h2;
        in_exe_cmd = 4'h9; in_wb_en = 1; in_s = 1; in_status = 4'h6; in_val_rn = 32'h77;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL load: got %h expected %h", obs_s, exp_s); end
        checks++;
        if (val_rm !== 32'h0000_00F0 || shift_operand !== 12'h0E1 || valid !== 1'b1) begin
            errors++; $display("FAIL load_fields: val_rm=%h sh=%h valid=%b required F0/0E1/1", val_rm, shift_operand, valid);
        end
        // invalid instruction with control bits set: controls masked, bubble counted
        in_valid = 0; in_mem_r_en = 1; in_mem_w_en = 1; in_wb_en = 1; in_b = 1; in_s = 1;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL invalid_load: got %h expected %h", obs_s, exp_s); end
        checks++;
        if ({mem_r_en, mem_w_en, wb_en, b, s} !== 5'b0 || bubble_cnt !== 4'h1) begin
            errors++; $display("FAIL invalid_ctrl: ctrl=%b bubble=%h required 0/1", {mem_r_en, mem_w_en, wb_en, b, s}, bubble_cnt);
        end
        idle_ins();
    endtask

    task automatic test_freeze();
        freeze = 1; clr_cnt = 1;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL freeze_clr: got %h expected %h", obs_s, exp_s); end
        idle_ins();
        in_dest = 4'h5;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL freeze_load: got %h expected %h", obs_s, exp_s); end
        freeze = 1; in_dest = 4'hA;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
            if (obs_s !== exp_s || dest !== 4'h5) begin
                errors++; $display("FAIL freeze_hold%0d: got %h expected %h", i, obs_s, exp_s);
            end
        end
        checks++;
        if (stall_cnt !== 4'h3) begin errors++; $display("FAIL freeze_stall: got %h required 3", stall_cnt); end
        freeze = 0;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s || dest !== 4'hA) begin
            errors++; $display("FAIL freeze_release: got %h expected %h", obs_s, exp_s);
        end
        idle_ins();
    endtask

    task automatic test_flush();
        in_wb_en = 1; in_mem_w_en = 1; in_dest = 4'h7; in_pc = 32'h200;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL flush_pre: got %h expected %h", obs_s, exp_s); end
        freeze = 1; flush = 1;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL flush_prio: got %h expected %h", obs_s, exp_s); end
        checks++;
        if (valid !== 1'b0 || wb_en !== 1'b0 || mem_w_en !== 1'b0 || stall_cnt !== exp_s.stall) begin
            errors++; $display("FAIL flush_bubble: valid=%b wb=%b mw=%b stall=%h", valid, wb_en, mem_w_en, stall_cnt);
        end
        idle_ins();
    endtask

    task automatic test_forwarding();
        logic [31:0] req[4];
        req[0] = 32'h1; req[1] = 32'h2; req[2] = 32'h3; req[3] = 32'h1;
        in_val_rm = 32'h1; in_val_rn = 32'h10;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL fwd_load: got %h expected %h", obs_s, exp_s); end
        mem_fwd_val = 32'h2; wb_fwd_val = 32'h3; freeze = 1;
        for (int i = 0; i < 4; i++) begin
            fwd_sel_rm = 2'(i); fwd_sel_rn = 2'(3 - i);
            sb_q.push_back(exp_snap());
            #1;
            exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
            if (obs_s !== exp_s || val_rm !== req[i]) begin
                errors++; $display("FAIL fwd_sel%0d: val_rm=%h required %h (snap %h vs %h)", i, val_rm, req[i], obs_s, exp_s);
            end
        end
        idle_ins();
    endtask

    task automatic test_saturation();
        freeze = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL sat_stall%0d: got %h expected %h", i, obs_s, exp_s); end
        end
        checks++;
        if (stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall_max: got %h required F", stall_cnt); end
        clr_cnt = 1;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s || stall_cnt !== 4'h0) begin
            errors++; $display("FAIL sat_clear: got %h expected %h", obs_s, exp_s);
        end
        idle_ins();
        in_valid = 0;
        for (int i = 0; i < 20; i++) begin
            flush = (i % 3 == 0);
            tick();
            exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL sat_bubble%0d: got %h expected %h", i, obs_s, exp_s); end
        end
        checks++;
        if (bubble_cnt !== 4'hF) begin errors++; $display("FAIL sat_bubble_max: got %h required F", bubble_cnt); end
        idle_ins();
    endtask

    task automatic test_back_to_back();
        clr_cnt = 1;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s) begin errors++; $display("FAIL b2b_clr: got %h expected %h", obs_s, exp_s); end
        for (int i = 0; i < 60; i++) begin
            rand_ins();
            freeze = ($urandom_range(3) == 0);
            flush = ($urandom_range(7) == 0);
            clr_cnt = ($urandom_range(15) == 0);
            tick();
            exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
            if (obs_s !== exp_s) begin errors++; $display("FAIL b2b%0d: got %h expected %h", i, obs_s, exp_s); end
        end
        idle_ins();
    endtask

    task automatic test_async_reset();
        in_valid = 1; in_wb_en = 1; in_pc = 32'hABC; in_dest = 4'hC;
        tick();
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s || valid !== 1'b1) begin
            errors++; $display("FAIL areset_pre: got %h expected %h", obs_s, exp_s);
        end
        #2;
        rst = 0;
        m = '0;
        sb_q.push_back(exp_snap());
        #1;
        exp_s = sb_q.pop_front(); obs_s = obs_snap(); checks++;
        if (obs_s !== exp_s || valid !== 1'b0) begin
            errors++; $display("FAIL areset_now: got %h expected %h", obs_s, exp_s);
        end
        @(posedge clk); #1;
        rst = 1;
        idle_ins();
    endtask

    initial begin
        rst = 0;
        idle_ins();
        test_reset();
        test_load();
        test_freeze();
        test_flush();
        test_forwarding();
        test_saturation();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
